noc_inport_router: RTL
======================

Name: noc_inport_router

Overview:
Parametrised input-port router for the 2D-mesh NoC, the successor to the single-mode input switch. It buffers incoming flits in a register FIFO and decodes the destination (x,y) from the flit header. It then forwards each flit to one of 5 output registers (N/E/S/W/Local) using a valid/ready handshake, in either dimension-ordered XY mode or distance-adaptive mode. It sits at each router input, feeding the per-output arbiters.

Parameters:
DATA_WIDTH, 288, flit width; dest x = data[DW-1 -: POS_WIDTH], dest y = next POS_WIDTH bits below it
POS_WIDTH, 4, coordinate width (unsigned)
POS_X, 0, this router's x coordinate
POS_Y, 0, this router's y coordinate
FIFO_DEPTH, 8, input FIFO entries; power of 2, >=2
ROUTE_MODE, 0, 0 = XY dimension-order; 1 = adaptive (larger-distance axis first, fallback to other productive axis)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
in_data  in  DATA_WIDTH  incoming flit
in_valid  in  1  flit present
in_ready  out  1  FIFO can accept
out_data  out  5*DATA_WIDTH  per-port flit; slice p = [p*DW +: DW]
out_valid  out  5  per-port valid; bit 0 N, 1 E, 2 S, 3 W, 4 Local
out_ready  in  5  per-port downstream accept
fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async): FIFO pointers and count = 0, in_ready = 0 while rst is high and 1 after, out_valid = 0, out_data = 0. Any flit in flight is discarded.
- Accept: a flit is written on the clk edge when in_valid && in_ready. in_ready = (count != FIFO_DEPTH). There is no write-through-when-full, even if a read occurs in the same cycle.
- Direction terms (unsigned): N = y<POS_Y, S = y>POS_Y, E = x>POS_X, W = x<POS_X, Local = x==POS_X && y==POS_Y.
- XY mode:
  - x != POS_X → E or W.
  - else y != POS_Y → N or S.
  - else Local.
  - The route is fixed; the head waits until that port is free.
- Adaptive mode:
  - dx = |x-POS_X|, dy = |y-POS_Y|.
  - Preferred axis: X if dx>=dy, else Y.
  - If the preferred port is not free and the other axis is productive (its distance != 0) and its port is free, use the other axis; otherwise wait.
- Port p is free when !out_valid[p] || out_ready[p]. This allows back-to-back issue to a draining port.
- Issue: at most one flit per cycle, always from the FIFO head. On issue, the head is popped, out_data[p] is loaded and out_valid[p] is set on the same edge.
- out_valid[p] clears on the edge where out_ready[p] is high, unless a new flit is issued to p on that edge.
- out_data[p] is stable while out_valid[p] && !out_ready[p].
- Latency: a flit accepted at edge N has out_valid high after edge N+1 when its FIFO is empty and its port is free.
- Ordering: head-of-line. Flits leave in arrival order; a blocked head stalls all flits behind it.
- Simultaneous push and pop: count is unchanged. Pointers wrap modulo FIFO_DEPTH.
- Empty FIFO: no issue, outputs only drain.

Optional Feature:
- Macro: NOC_INPORT_STATS_EN.
- Defined: adds output ports stat_flits_in[31:0] (accepted flits) and stat_stall_cycles[31:0] (cycles with FIFO non-empty and no issue). Both are saturating at 32'hFFFF_FFFF and cleared by rst.
- Not defined: these ports and their logic are absent. Core behaviour is identical in both cases.

Test Plan:
- POS=(2,2), mode 0, all out_ready=1: send flit dest (2,2) → out_valid=5'b10000 one cycle after accept, then 0 the next cycle.
- Mode 0: dest (5,0) → E (5'b00010); dest (2,0) → N (5'b00001).
- Mode 1: dest (3,0) (dx=1, dy=2) → N. With out_ready[1]=0, send two flits to (5,4) (dx=3, dy=2) → first to E, second falls back to S (5'b00100); E holds its data until ready.
- FIFO_DEPTH=8, out_ready=0, 12 flits to Local → 9 accepted (1 in output reg + 8 in FIFO), in_ready=0, fifo_count=8. Then out_ready[4]=1 → 9 flits emerge in order, one per cycle.
- Assert rst mid-stream with 5 flits queued → out_valid=0 and fifo_count=0 immediately, with no clock required. After release, a new flit routes normally.
- With NOC_INPORT_STATS_EN, rerun the FIFO-fill scenario → stat_flits_in=9, stat_stall_cycles equals the number of cycles with out_ready[4]=0 and FIFO non-empty.

Source files
------------

// File: rtl/noc_inport_router.sv
// rtl/noc_inport_router.sv - NoC mesh input port: register FIFO plus XY or distance-adaptive output selection
// Defining NOC_INPORT_STATS_EN adds saturating accepted-flit and stall-cycle counters.
module noc_inport_router #(
  parameter int DATA_WIDTH = 288,
  parameter int POS_WIDTH  = 4,
  parameter int POS_X      = 0,
  parameter int POS_Y      = 0,
  parameter int FIFO_DEPTH = 8,
  parameter int ROUTE_MODE = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_WIDTH-1:0]         in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [5*DATA_WIDTH-1:0]       out_data,
  output logic [4:0]                    out_valid,
  input  logic [4:0]                    out_ready,
`ifdef NOC_INPORT_STATS_EN
  output logic [31:0]                   stat_flits_in,
  output logic [31:0]                   stat_stall_cycles,
`endif
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0]        FULL = CW'(FIFO_DEPTH);
  localparam logic [POS_WIDTH-1:0] PX   = POS_WIDTH'(POS_X);
  localparam logic [POS_WIDTH-1:0] PY   = POS_WIDTH'(POS_Y);

  logic [DATA_WIDTH-1:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]           count_q, count_d;
  logic [4:0]              out_valid_q, out_valid_d;
  logic [5*DATA_WIDTH-1:0] out_data_q;
  logic                    push, pop;
  logic [DATA_WIDTH-1:0]   head;
  logic [POS_WIDTH-1:0]    dst_x, dst_y, dist_x, dist_y;
  logic [4:0]              port_free, x_port, y_port, issue_oh;

  assign head   = mem_q[rd_ptr_q];
  assign dst_x  = head[DATA_WIDTH-1 -: POS_WIDTH];
  assign dst_y  = head[DATA_WIDTH-1-POS_WIDTH -: POS_WIDTH];
  assign dist_x = (dst_x >= PX) ? (dst_x - PX) : (PX - dst_x);
  assign dist_y = (dst_y >= PY) ? (dst_y - PY) : (PY - dst_y);
  assign x_port = (dst_x > PX) ? 5'b00010 : 5'b01000;
  assign y_port = (dst_y < PY) ? 5'b00001 : 5'b00100;

  // A port holding a flit is still free if it drains this edge, allowing back-to-back issue.
  assign port_free = ~out_valid_q | out_ready;

  always_comb begin
    issue_oh = '0;
    if (count_q != '0) begin
      if ((dist_x == '0) && (dist_y == '0)) begin
        if (port_free[4]) issue_oh = 5'b10000;
      end else if (ROUTE_MODE == 0) begin
        if (dist_x != '0) begin
          if ((x_port & port_free) != '0) issue_oh = x_port;
        end else if ((y_port & port_free) != '0) begin
          issue_oh = y_port;
        end
      end else if (dist_x >= dist_y) begin
        if ((x_port & port_free) != '0) issue_oh = x_port;
        else if ((dist_y != '0) && ((y_port & port_free) != '0)) issue_oh = y_port;
      end else begin
        if ((y_port & port_free) != '0) issue_oh = y_port;
        else if ((dist_x != '0) && ((x_port & port_free) != '0)) issue_oh = x_port;
      end
    end
  end

  assign in_ready = ~rst & (count_q != FULL);
  assign push     = in_valid & in_ready;
  assign pop      = |issue_oh;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    out_valid_d = (out_valid_q & ~out_ready) | issue_oh;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= '0;
      out_data_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      for (int p = 0; p < 5; p++) begin
        if (issue_oh[p]) out_data_q[p*DATA_WIDTH +: DATA_WIDTH] <= head;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign fifo_count = count_q;

`ifdef NOC_INPORT_STATS_EN
  logic [31:0] flits_q, stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flits_q <= '0;
      stall_q <= '0;
    end else begin
      if (push && (flits_q != 32'hFFFF_FFFF)) flits_q <= flits_q + 1'b1;
      if ((count_q != '0) && !pop && (stall_q != 32'hFFFF_FFFF)) stall_q <= stall_q + 1'b1;
    end
  end

  assign stat_flits_in     = flits_q;
  assign stat_stall_cycles = stall_q;
`endif

endmodule
